hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 17 +
 rtl/hazard_control_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: FSM state encoding, pipeline control bundle,
// and the default memory-wait timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hcu_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 64;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational detector for a load in EX whose destination is read by the instruction in ID.
module load_use_detect (
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_use_rs1,
  input  logic       ID_use_rs2,
  input  logic       ID_EX_mem_read,
  input  logic [4:0] ID_EX_rd,
  output logic       load_use
);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                    ((ID_use_rs1 && (ID_rs1 == ID_EX_rd)) ||
                     (ID_use_rs2 && (ID_rs2 == ID_EX_rd)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: freeze on data-memory wait, flush on mispredict, one-cycle
// load-use stall, sticky halt/error. Optional statistics counters under HAZARD_STATS_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_EX_mem_read,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_mispredict,
  input  logic             MEM_dmem_req,
  input  logic             dmem_ready,
  input  logic             WB_halt,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             is_halted,
  output logic             mem_error
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_count
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  hcu_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              load_use;
  logic              running;
  logic              freeze;
  logic              stall_evt;
  logic              flush_evt;
  ctrl_t             ctrl;

  load_use_detect u_load_use_detect (
    .ID_rs1         (ID_rs1),
    .ID_rs2         (ID_rs2),
    .ID_use_rs1     (ID_use_rs1),
    .ID_use_rs2     (ID_use_rs2),
    .ID_EX_mem_read (ID_EX_mem_read),
    .ID_EX_rd       (ID_EX_rd),
    .load_use       (load_use)
  );

  // While reset is held the outputs behave as in RUN, even if the FSM is still HALTED.
  assign running   = !reset_n || (state != HALTED);
  assign freeze    = running && MEM_dmem_req && !dmem_ready;
  assign stall_evt = running && !freeze && !EX_mispredict && load_use;
  assign flush_evt = running && !freeze && EX_mispredict;
  assign wait_inc  = wait_cnt + WAIT_ONE;

  // NOTE: ctrl gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (!running || freeze) ctrl = CTRL_FROZEN;
    else if (EX_mispredict)  ctrl = CTRL_FLUSH;
    else if (load_use)       ctrl = CTRL_LOAD_USE;
  end

  assign PC_write     = ctrl.pc_write;
  assign IF_ID_write  = ctrl.if_id_write;
  assign ID_EX_write  = ctrl.id_ex_write;
  assign EX_MEM_write = ctrl.ex_mem_write;
  assign MEM_WB_write = ctrl.mem_wb_write;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_bubble = ctrl.id_ex_bubble;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      is_halted <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (freeze) begin
            wait_cnt <= WAIT_ONE;
            if (WAIT_ONE >= WAIT_LIMIT) begin
              mem_error <= 1'b1;
              state     <= HALTED;
            end else begin
              state <= MEM_WAIT;
            end
          end else if (WB_halt) begin
            is_halted <= 1'b1;
            state     <= HALTED;
          end
        end
        MEM_WAIT: begin
          // WB is frozen here, so a pending WB_halt is acted on once back in RUN.
          if (freeze) begin
            wait_cnt <= wait_inc;
            if (wait_inc >= WAIT_LIMIT) begin
              mem_error <= 1'b1;
              state     <= HALTED;
            end
          end else begin
            state <= RUN;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_count  <= '0;
      flush_count  <= '0;
      freeze_count <= '0;
    end else begin
      if (stall_evt && (stall_count != '1))   stall_count  <= stall_count + CNT_ONE;
      if (flush_evt && (flush_count != '1))   flush_count  <= flush_count + CNT_ONE;
      if (freeze && (freeze_count != '1))     freeze_count <= freeze_count + CNT_ONE;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule
